// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator sequencer and the Operaciones unit:
// opcodes, FSM states and instruction field extraction.
package alu_pkg;

   localparam logic [2:0] OP_SUM  = 3'd0;
   localparam logic [2:0] OP_COMP = 3'd1;
   localparam logic [2:0] OP_SHL  = 3'd2;
   localparam logic [2:0] OP_SHR  = 3'd3;
   localparam logic [2:0] OP_EQ   = 3'd4;
   localparam logic [2:0] OP_GT   = 3'd5;
   localparam logic [2:0] OP_LDI  = 3'd6;
   localparam logic [2:0] OP_OUT  = 3'd7;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC1  = 3'd2,
      EXEC2  = 3'd3,
      WB     = 3'd4
   } state_t;

   function automatic logic [2:0] get_opc(input logic [7:0] ins);
      return ins[7:5];
   endfunction

   function automatic logic [3:0] get_imm(input logic [7:0] ins);
      return ins[3:0];
   endfunction

   function automatic logic [1:0] get_ridx(input logic [7:0] ins);
      return ins[1:0];
   endfunction

endpackage

// File: rtl/unidad_control_if.sv
// Program-memory and execution-unit bus between the sequencer (master)
// and its environment (slave).
interface unidad_control_if #(
   parameter int PC_W = 4
);
   logic            run;
   logic [PC_W-1:0] prog_addr;
   logic [7:0]      prog_data;
   logic [7:0]      instr;
   logic [3:0]      A;
   logic [3:0]      B;
   logic [3:0]      dato_mux;
   logic            rd;
   logic [3:0]      dato_outlo;
   logic [3:0]      out_port;
   logic            out_valid;
   logic [3:0]      acc;
   logic            wb_err;

   modport master (
      input  run, prog_data, dato_mux, rd, dato_outlo,
      output prog_addr, instr, A, B, out_port, out_valid, acc, wb_err
   );

   modport slave (
      output run, prog_data, dato_mux, rd, dato_outlo,
      input  prog_addr, instr, A, B, out_port, out_valid, acc, wb_err
   );
endinterface

// File: rtl/banco_registros.sv
// 4x4-bit register file: one synchronous write port, one combinational
// read port, asynchronously cleared.
module banco_registros (
   input  logic       clk,
   input  logic       rst,
   input  logic       we,
   input  logic [1:0] waddr,
   input  logic [3:0] wdata,
   input  logic [1:0] raddr,
   output logic [3:0] rdata
);

   logic [3:0] regs_r [0:3];

   // storage with clear on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            regs_r[i] <= 4'd0;
         end
      end else if (we) begin
         regs_r[waddr] <= wdata;
      end
   end

   assign rdata = regs_r[raddr];

endmodule

// File: rtl/unidad_control.sv
// Accumulator sequencer: fetches instructions, holds instr/A/B stable across
// the execution unit's two-edge pipeline and commits its result in WB.
module unidad_control
   import alu_pkg::*;
#(
   parameter int PC_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   unidad_control_if.master  bus
);

   state_t          state_r;
   state_t          state_nx_s;
   logic            ld_ir_s;
   logic            ld_ops_s;
   logic            commit_s;
   logic            is_out_s;
   logic            rf_we_s;
   logic [3:0]      rdata_s;

   logic [PC_W-1:0] pc_r;
   logic [7:0]      ir_r;
   logic [7:0]      instr_r;
   logic [3:0]      a_r;
   logic [3:0]      b_r;
   logic [3:0]      acc_r;
   logic [3:0]      out_port_r;
   logic            out_valid_r;
   logic            wb_err_r;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= FETCH;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // next-state and per-state strobes
   always_comb begin
      state_nx_s = state_r;
      ld_ir_s    = 1'b0;
      ld_ops_s   = 1'b0;
      commit_s   = 1'b0;
      case (state_r)
         FETCH: begin
            if (bus.run) begin
               ld_ir_s    = 1'b1;
               state_nx_s = DECODE;
            end else begin
               state_nx_s = FETCH;
            end
         end
         DECODE: begin
            ld_ops_s   = 1'b1;
            state_nx_s = EXEC1;
         end
         EXEC1:   state_nx_s = EXEC2;
         EXEC2:   state_nx_s = WB;
         WB: begin
            commit_s   = 1'b1;
            state_nx_s = FETCH;
         end
         default: state_nx_s = FETCH;
      endcase
   end

   assign is_out_s = (get_opc(instr_r) == OP_OUT);
   assign rf_we_s  = commit_s & is_out_s;

   banco_registros u_regs (
      .clk   (clk),
      .rst   (rst),
      .we    (rf_we_s),
      .waddr (get_ridx(instr_r)),
      .wdata (acc_r),
      .raddr (get_ridx(ir_r)),
      .rdata (rdata_s)
   );

   // instruction and operand registers, frozen from DECODE until the next DECODE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir_r    <= 8'd0;
         instr_r <= 8'd0;
         a_r     <= 4'd0;
         b_r     <= 4'd0;
      end else begin
         if (ld_ir_s) begin
            ir_r <= bus.prog_data;
         end
         if (ld_ops_s) begin
            instr_r <= ir_r;
            a_r     <= acc_r;
            b_r     <= rdata_s;
         end
      end
   end

   // write-back: op 7 drives the port, all others take the unit's result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_r        <= {PC_W{1'b0}};
         acc_r       <= 4'd0;
         out_port_r  <= 4'd0;
         out_valid_r <= 1'b0;
         wb_err_r    <= 1'b0;
      end else begin
         out_valid_r <= rf_we_s;
         if (commit_s) begin
            pc_r <= pc_r + {{(PC_W-1){1'b0}}, 1'b1};
            if (is_out_s) begin
               out_port_r <= bus.dato_outlo;
            end else if (bus.rd) begin
               acc_r <= bus.dato_mux;
            end else begin
               wb_err_r <= 1'b1;
            end
         end
      end
   end

   assign bus.prog_addr = pc_r;
   assign bus.instr     = instr_r;
   assign bus.A         = a_r;
   assign bus.B         = b_r;
   assign bus.acc       = acc_r;
   assign bus.out_port  = out_port_r;
   assign bus.out_valid = out_valid_r;
   assign bus.wb_err    = wb_err_r;

endmodule

// File: tb/tb_unidad_control.sv
// Bench for unidad_control: a behavioural Operaciones unit plus an ISA-level
// scoreboard of the expected architectural state after every instruction.
module tb_unidad_control;
   import alu_pkg::*;

   typedef struct {
      logic [7:0] instr;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] acc;
      logic [3:0] out_port;
      logic       out_valid;
      logic       wb_err;
      logic       frc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic force_rd0 = 1'b0;
   logic [7:0] prog_mem [0:15];
   int checks = 0;
   int errors = 0;

   exp_t       sb[$];
   logic [3:0] m_acc;
   logic [3:0] m_regs [0:3];
   logic [3:0] m_out;
   logic       m_err;
   int         ld_ptr;

   unidad_control_if #(.PC_W(4)) bus ();
   unidad_control #(.PC_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   assign bus.prog_data = prog_mem[bus.prog_addr];

   function automatic logic [3:0] calc(input logic [2:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] imm);
      case (op)
         3'd0:    calc = a + b;
         3'd1:    calc = ~a;
         3'd2:    calc = {a[2:0], 1'b0};
         3'd3:    calc = {1'b0, a[3:1]};
         3'd4:    calc = {3'b000, (a == b)};
         3'd5:    calc = {3'b000, (a > b)};
         3'd6:    calc = imm;
         default: calc = 4'd0;
      endcase
   endfunction

   // execution-unit model: result presented at each negedge
   always @(negedge clk) begin
      bus.dato_mux   = calc(bus.instr[7:5], bus.A, bus.B, bus.instr[3:0]);
      bus.rd         = ~force_rd0;
      bus.dato_outlo = bus.A;
   end

   task automatic reset_all();
      rst = 1'b1;
      bus.run = 1'b0;
      force_rd0 = 1'b0;
      sb.delete();
      m_acc = 4'd0;
      m_out = 4'd0;
      m_err = 1'b0;
      for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
      for (int i = 0; i < 16; i++) prog_mem[i] = 8'hC0;
      ld_ptr = 0;
      @(posedge clk); #1;
   endtask

   task automatic push_instr(input logic [7:0] ins, input logic frc);
      exp_t e;
      logic [2:0] op;
      logic [1:0] ix;
      op = ins[7:5];
      ix = ins[1:0];
      e.instr = ins;
      e.a = m_acc;
      e.b = m_regs[ix];
      e.frc = frc;
      e.out_valid = 1'b0;
      if (op == 3'd7) begin
         m_regs[ix] = m_acc;
         m_out = m_acc;
         e.out_valid = 1'b1;
      end else if (frc) begin
         m_err = 1'b1;
      end else begin
         m_acc = calc(op, m_acc, e.b, ins[3:0]);
      end
      e.acc = m_acc;
      e.out_port = m_out;
      e.wb_err = m_err;
      sb.push_back(e);
      prog_mem[ld_ptr] = ins;
      ld_ptr++;
   endtask

   task automatic start_run();
      bus.run = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_checks();
      exp_t e;
      logic prev_ov;
      prev_ov = 1'b0;
      while (sb.size() > 0) begin
         force_rd0 = sb[0].frc;
         @(posedge clk); #1;
         if (prev_ov) begin
            checks++;
            if (bus.out_valid !== 1'b0) begin
               errors++;
               $display("FAIL out_valid_pulse: got %b expected 0", bus.out_valid);
            end
         end
         repeat (4) @(posedge clk);
         #1;
         e = sb.pop_front();
         checks++;
         if (bus.acc !== e.acc) begin
            errors++;
            $display("FAIL acc[%h]: got %h expected %h", e.instr, bus.acc, e.acc);
         end
         checks++;
         if ({bus.instr, bus.A, bus.B} !== {e.instr, e.a, e.b}) begin
            errors++;
            $display("FAIL operands[%h]: got instr=%h A=%h B=%h expected instr=%h A=%h B=%h",
                     e.instr, bus.instr, bus.A, bus.B, e.instr, e.a, e.b);
         end
         checks++;
         if ({bus.out_port, bus.out_valid} !== {e.out_port, e.out_valid}) begin
            errors++;
            $display("FAIL out[%h]: got port=%h valid=%b expected port=%h valid=%b",
                     e.instr, bus.out_port, bus.out_valid, e.out_port, e.out_valid);
         end
         checks++;
         if (bus.wb_err !== e.wb_err) begin
            errors++;
            $display("FAIL wb_err[%h]: got %b expected %b", e.instr, bus.wb_err, e.wb_err);
         end
         prev_ov = e.out_valid;
      end
      force_rd0 = 1'b0;
   endtask

   task automatic test_reset();
      reset_all();
      checks++;
      if ({bus.prog_addr, bus.instr, bus.A, bus.B, bus.acc, bus.out_port, bus.out_valid, bus.wb_err} !== 30'd0) begin
         errors++;
         $display("FAIL reset_values: got pc=%h instr=%h A=%h B=%h acc=%h out=%h ov=%b err=%b expected all zero",
                  bus.prog_addr, bus.instr, bus.A, bus.B, bus.acc, bus.out_port, bus.out_valid, bus.wb_err);
      end
      prog_mem[0] = 8'hC5;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if ({bus.prog_addr, bus.instr, bus.acc} !== 16'd0) begin
         errors++;
         $display("FAIL idle_no_run: got pc=%h instr=%h acc=%h expected 0 0 0",
                  bus.prog_addr, bus.instr, bus.acc);
      end
   endtask

   task automatic test_ldi();
      reset_all();
      push_instr(8'hC5, 1'b0);
      start_run();
      run_checks();
   endtask

   task automatic test_out_add();
      reset_all();
      push_instr(8'hC5, 1'b0);
      push_instr(8'hE1, 1'b0);
      push_instr(8'hC3, 1'b0);
      push_instr(8'h01, 1'b0);
      start_run();
      run_checks();
   endtask

   task automatic test_overflow();
      reset_all();
      push_instr(8'hC9, 1'b0);
      push_instr(8'hE2, 1'b0);
      push_instr(8'hC7, 1'b0);
      push_instr(8'h02, 1'b0);
      start_run();
      run_checks();
   endtask

   task automatic test_compare();
      reset_all();
      push_instr(8'hC8, 1'b0);
      push_instr(8'hE3, 1'b0);
      push_instr(8'hC5, 1'b0);
      push_instr(8'hA3, 1'b0);
      push_instr(8'h83, 1'b0);
      push_instr(8'hC8, 1'b0);
      push_instr(8'h83, 1'b0);
      start_run();
      run_checks();
   endtask

   task automatic test_wb_err();
      reset_all();
      push_instr(8'hC4, 1'b0);
      push_instr(8'h00, 1'b1);
      push_instr(8'hC2, 1'b0);
      push_instr(8'h00, 1'b0);
      start_run();
      run_checks();
   endtask

   task automatic test_run_drop_and_async_rst();
      exp_t e;
      reset_all();
      push_instr(8'hC1, 1'b0);
      push_instr(8'hC2, 1'b0);
      start_run();
      run_checks();
      push_instr(8'hC3, 1'b0);
      push_instr(8'hC4, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      bus.run = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if ({bus.acc, bus.instr} !== {e.acc, e.instr}) begin
         errors++;
         $display("FAIL run_drop_commit: got acc=%h instr=%h expected acc=%h instr=%h",
                  bus.acc, bus.instr, e.acc, e.instr);
      end
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if ({bus.prog_addr, bus.instr, bus.acc} !== {4'd3, 8'hC3, 4'd3}) begin
         errors++;
         $display("FAIL run_drop_park: got pc=%h instr=%h acc=%h expected pc=3 instr=c3 acc=3",
                  bus.prog_addr, bus.instr, bus.acc);
      end
      bus.run = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.prog_addr, bus.instr, bus.A, bus.B, bus.acc, bus.out_port, bus.out_valid, bus.wb_err} !== 30'd0) begin
         errors++;
         $display("FAIL async_rst: got pc=%h instr=%h A=%h B=%h acc=%h out=%h ov=%b err=%b expected all zero",
                  bus.prog_addr, bus.instr, bus.A, bus.B, bus.acc, bus.out_port, bus.out_valid, bus.wb_err);
      end
      sb.delete();
   endtask

   initial begin
      test_reset();
      test_ldi();
      test_out_add();
      test_overflow();
      test_compare();
      test_wb_err();
      test_run_drop_and_async_rst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
